switch_box_cfg: RTL and testbench



---
 rtl/switch_box_cfg.sv | 190 +++++++++++++++++++
 tb/tb_switch_box_cfg.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_box_cfg.sv
// switch_box_cfg: parametrised Wilton switchbox with an integrated serial
// configuration chain (shadow register, bit counter, commit state machine).
//
// Ports:
//   clock, reset          : single rising-edge clock, synchronous active-high reset
//   data_<side>_in/_out   : WIDTH tracks per side (north, east, south, west)
//   data_from_les         : LE_IN signals from logic elements into the box
//   data_to_les           : LE_OUT signals from the box to logic elements
//   config_enable/_in     : shift one config bit per enabled cycle
//   config_out            : serial chain output (shadow bit 0) for daisy-chaining
//   config_commit         : copy shadow -> active, only legal after exactly CW shifts
//   config_loaded         : exactly CW bits shifted since last commit/reset
//   config_error          : last commit failed; sticky until a good commit or reset
//
// Config layout (LSB first): north/east/south/west track selects (SIC bits
// each, WIDTH per side), then LE_OUT LE selects of SLE bits each.

// Generic N:1 mux; selects at or above N drive 0.
module sbc_mux #(
    parameter int N  = 2,
    parameter int SW = 1
) (
    input  logic [N-1:0]  in_vec,
    input  logic [SW-1:0] sel,
    output logic          out_o
);
    assign out_o = ({1'b0, sel} < (SW+1)'(N)) ? in_vec[sel] : 1'b0;
endmodule

module switch_box_cfg #(
    parameter int WIDTH            = 6,
    parameter int LE_IN            = 2,
    parameter int LE_OUT           = 8,
    parameter int REGISTER_OUTPUTS = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  data_north_in,
    output logic [WIDTH-1:0]  data_north_out,
    input  logic [WIDTH-1:0]  data_east_in,
    output logic [WIDTH-1:0]  data_east_out,
    input  logic [WIDTH-1:0]  data_south_in,
    output logic [WIDTH-1:0]  data_south_out,
    input  logic [WIDTH-1:0]  data_west_in,
    output logic [WIDTH-1:0]  data_west_out,
    input  logic [LE_IN-1:0]  data_from_les,
    output logic [LE_OUT-1:0] data_to_les,
    input  logic              config_enable,
    input  logic              config_in,
    output logic              config_out,
    input  logic              config_commit,
    output logic              config_loaded,
    output logic              config_error
);
    localparam int SIC  = $clog2(3 + LE_IN);
    localparam int SLE  = $clog2(4 * WIDTH + LE_IN);
    localparam int CW   = 4 * WIDTH * SIC + LE_OUT * SLE;
    localparam int NTRK = LE_IN + 3;
    localparam int NLE  = 4 * WIDTH + LE_IN;
    localparam int CNTW = $clog2(CW + 1);
    localparam int LEB  = 4 * WIDTH * SIC;

    typedef enum logic [1:0] {IDLE, SHIFTING, LOADED, OVER} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]   shadow_q, shadow_d;
    logic [CW-1:0]   active_q, active_d;
    logic            err_q, err_d;
    logic            commit_ok, commit_bad;

    // ---------------- config state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            err_q    <= err_d;
        end
    end

    // ---------------- next state ----------------
    // An enabled cycle always wins over commit; the commit is then dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (config_enable) begin
            case (state_q)
                IDLE, SHIFTING: begin
                    cnt_d   = cnt_q + CNTW'(1);
                    state_d = (cnt_q == CNTW'(CW - 1)) ? LOADED : SHIFTING;
                end
                LOADED:  state_d = OVER;
                default: state_d = OVER;  // count frozen once over-shifted
            endcase
        end else if (config_commit) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // ---------------- outputs / datapath of the config chain ----------------
    always_comb begin
        commit_ok  = config_commit && !config_enable && (state_q == LOADED);
        commit_bad = config_commit && (config_enable || (state_q != LOADED));
        shadow_d   = config_enable ? {config_in, shadow_q[CW-1:1]} : shadow_q;
        active_d   = commit_ok ? shadow_q : active_q;
        err_d      = err_q;
        if (commit_ok)       err_d = 1'b0;
        else if (commit_bad) err_d = 1'b1;
        config_loaded = (state_q == LOADED);
        config_out    = shadow_q[0];
        config_error  = err_q;
    end

    // ---------------- routing muxes ----------------
    logic [WIDTH-1:0]  nout_d, eout_d, sout_d, wout_d;
    logic [LE_OUT-1:0] le_d;
    logic [NLE-1:0]    le_v;

    // LE mux input order: LEs, then west, south, east, north tracks.
    assign le_v = {data_north_in, data_east_in, data_south_in, data_west_in, data_from_les};

    genvar i, j;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_trk
            localparam int IP1 = (i + 1) % WIDTH;
            localparam int IWR = (WIDTH - i) % WIDTH;
            localparam int I2W = (2 * WIDTH - 2 - i) % WIDTH;
            logic [NTRK-1:0] n_v, e_v, s_v, w_v;

            assign n_v = {data_west_in[IP1],  data_south_in[i], data_east_in[IWR],  data_from_les};
            assign e_v = {data_north_in[IWR], data_west_in[i],  data_south_in[IP1], data_from_les};
            assign s_v = {data_east_in[IP1],  data_north_in[i], data_west_in[I2W],  data_from_les};
            assign w_v = {data_south_in[I2W], data_east_in[i],  data_north_in[IP1], data_from_les};

            sbc_mux #(.N(NTRK), .SW(SIC)) u_n (.in_vec(n_v),
                .sel(active_q[(0*WIDTH + i)*SIC +: SIC]), .out_o(nout_d[i]));
            sbc_mux #(.N(NTRK), .SW(SIC)) u_e (.in_vec(e_v),
                .sel(active_q[(1*WIDTH + i)*SIC +: SIC]), .out_o(eout_d[i]));
            sbc_mux #(.N(NTRK), .SW(SIC)) u_s (.in_vec(s_v),
                .sel(active_q[(2*WIDTH + i)*SIC +: SIC]), .out_o(sout_d[i]));
            sbc_mux #(.N(NTRK), .SW(SIC)) u_w (.in_vec(w_v),
                .sel(active_q[(3*WIDTH + i)*SIC +: SIC]), .out_o(wout_d[i]));
        end

        for (j = 0; j < LE_OUT; j++) begin : g_le
            sbc_mux #(.N(NLE), .SW(SLE)) u_le (.in_vec(le_v),
                .sel(active_q[LEB + j*SLE +: SLE]), .out_o(le_d[j]));
        end

        if (REGISTER_OUTPUTS != 0) begin : g_oreg
            logic [WIDTH-1:0]  nout_q, eout_q, sout_q, wout_q;
            logic [LE_OUT-1:0] le_q;
            always_ff @(posedge clock) begin
                if (reset) begin
                    nout_q <= '0;
                    eout_q <= '0;
                    sout_q <= '0;
                    wout_q <= '0;
                    le_q   <= '0;
                end else begin
                    nout_q <= nout_d;
                    eout_q <= eout_d;
                    sout_q <= sout_d;
                    wout_q <= wout_d;
                    le_q   <= le_d;
                end
            end
            assign data_north_out = nout_q;
            assign data_east_out  = eout_q;
            assign data_south_out = sout_q;
            assign data_west_out  = wout_q;
            assign data_to_les    = le_q;
        end else begin : g_comb
            assign data_north_out = nout_d;
            assign data_east_out  = eout_d;
            assign data_south_out = sout_d;
            assign data_west_out  = wout_d;
            assign data_to_les    = le_d;
        end
    endgenerate
endmodule

// File: tb/tb_switch_box_cfg.sv
// Bench for switch_box_cfg: two instances (default combinational build and a
// WIDTH=8/LE_IN=4 registered build) driven with random data and config
// streams, compared every cycle against a select-table reference model.
module tb_switch_box_cfg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst, ce, ci, cc;
    logic [3:0][7:0] din;   // [0]=north [1]=east [2]=south [3]=west
    logic [3:0]      les;

    logic [5:0] no0, eo0, so0, wo0;
    logic [7:0] lo0;
    logic       cout0, ld0, er0;
    logic [7:0] no1, eo1, so1, wo1, lo1;
    logic       cout1, ld1, er1;

    switch_box_cfg #(.WIDTH(6), .LE_IN(2), .LE_OUT(8), .REGISTER_OUTPUTS(0)) u_dut0 (
        .clock(clk), .reset(rst[0]),
        .data_north_in(din[0][5:0]), .data_north_out(no0),
        .data_east_in(din[1][5:0]),  .data_east_out(eo0),
        .data_south_in(din[2][5:0]), .data_south_out(so0),
        .data_west_in(din[3][5:0]),  .data_west_out(wo0),
        .data_from_les(les[1:0]), .data_to_les(lo0),
        .config_enable(ce[0]), .config_in(ci[0]), .config_out(cout0),
        .config_commit(cc[0]), .config_loaded(ld0), .config_error(er0));

    switch_box_cfg #(.WIDTH(8), .LE_IN(4), .LE_OUT(8), .REGISTER_OUTPUTS(1)) u_dut1 (
        .clock(clk), .reset(rst[1]),
        .data_north_in(din[0]), .data_north_out(no1),
        .data_east_in(din[1]),  .data_east_out(eo1),
        .data_south_in(din[2]), .data_south_out(so1),
        .data_west_in(din[3]),  .data_west_out(wo1),
        .data_from_les(les), .data_to_les(lo1),
        .config_enable(ce[1]), .config_in(ci[1]), .config_out(cout1),
        .config_commit(cc[1]), .config_loaded(ld1), .config_error(er1));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int w_of(int d);  return (d == 1) ? 8 : 6;     endfunction
    function automatic int lei(int d);   return (d == 1) ? 4 : 2;     endfunction
    function automatic int sle(int d);   return (d == 1) ? 6 : 5;     endfunction
    function automatic int cw(int d);    return (d == 1) ? 144 : 112; endfunction

    int              tsel [2][4][8];
    int              lsel [2][8];
    bit [143:0]      sh   [2];
    int              cnt  [2];
    bit              err  [2];
    bit [3:0][7:0]   oreg_t [2];
    bit [7:0]        oreg_l [2];

    function automatic bit trk_bit(int d, int s, int i, int k);
        int w = w_of(d);
        int r = k - lei(d);
        if (k < lei(d)) return les[k];
        case (s)
            0: case (r) 0: return din[1][(w-i)%w];     1: return din[2][i]; 2: return din[3][(i+1)%w];     default: return 1'b0; endcase
            1: case (r) 0: return din[2][(i+1)%w];     1: return din[3][i]; 2: return din[0][(w-i)%w];     default: return 1'b0; endcase
            2: case (r) 0: return din[3][(2*w-2-i)%w]; 1: return din[0][i]; 2: return din[1][(i+1)%w];     default: return 1'b0; endcase
            default: case (r) 0: return din[0][(i+1)%w]; 1: return din[1][i]; 2: return din[2][(2*w-2-i)%w]; default: return 1'b0; endcase
        endcase
    endfunction

    function automatic bit le_bit(int d, int k);
        int w = w_of(d);
        int r = k - lei(d);
        if (k < lei(d)) return les[k];
        if (r >= 4 * w) return 1'b0;
        return din[3 - r / w][r % w];   // west, south, east, north
    endfunction

    task automatic mdl_out(input int d, output bit [3:0][7:0] t, output bit [7:0] l);
        t = '0;
        l = '0;
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < w_of(d); i++) t[s][i] = trk_bit(d, s, i, tsel[d][s][i]);
        for (int j = 0; j < 8; j++) l[j] = le_bit(d, lsel[d][j]);
    endtask

    task automatic decode(input int d);
        int w = w_of(d);
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < w; i++) begin
                int v = 0;
                for (int b = 0; b < 3; b++) v += int'(sh[d][(s*w + i)*3 + b]) << b;
                tsel[d][s][i] = v;
            end
        for (int j = 0; j < 8; j++) begin
            int v = 0;
            for (int b = 0; b < sle(d); b++) v += int'(sh[d][4*w*3 + j*sle(d) + b]) << b;
            lsel[d][j] = v;
        end
    endtask

    // One clock: predict, advance the model, take the edge, compare.
    task automatic cyc();
        bit [3:0][7:0] pt [2];
        bit [7:0]      pl [2];
        for (int d = 0; d < 2; d++) mdl_out(d, pt[d], pl[d]);
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                sh[d] = '0; cnt[d] = 0; err[d] = 1'b0;
                oreg_t[d] = '0; oreg_l[d] = '0;
                for (int s = 0; s < 4; s++) for (int i = 0; i < 8; i++) tsel[d][s][i] = 0;
                for (int j = 0; j < 8; j++) lsel[d][j] = 0;
            end else begin
                oreg_t[d] = pt[d];
                oreg_l[d] = pl[d];
                if (ce[d]) begin
                    sh[d] = sh[d] >> 1;
                    sh[d][cw(d)-1] = ci[d];
                    if (cnt[d] <= cw(d)) cnt[d]++;
                    if (cc[d]) err[d] = 1'b1;
                end else if (cc[d]) begin
                    if (cnt[d] == cw(d)) begin decode(d); err[d] = 1'b0; end
                    else err[d] = 1'b1;
                    cnt[d] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            bit [3:0][7:0] et, gt;
            bit [7:0]      el, gl;
            bit            gld, ger, gco;
            if (d == 1) begin
                et = oreg_t[1]; el = oreg_l[1];
                gt[0] = no1; gt[1] = eo1; gt[2] = so1; gt[3] = wo1; gl = lo1;
                gld = ld1; ger = er1; gco = cout1;
            end else begin
                mdl_out(0, et, el);
                gt[0] = {2'b0, no0}; gt[1] = {2'b0, eo0}; gt[2] = {2'b0, so0}; gt[3] = {2'b0, wo0};
                gl = lo0; gld = ld0; ger = er0; gco = cout0;
            end
            chk($sformatf("d%0d_north", d), gt[0], et[0]);
            chk($sformatf("d%0d_east", d),  gt[1], et[1]);
            chk($sformatf("d%0d_south", d), gt[2], et[2]);
            chk($sformatf("d%0d_west", d),  gt[3], et[3]);
            chk($sformatf("d%0d_to_les", d), gl, el);
            chk($sformatf("d%0d_loaded", d), gld, cnt[d] == cw(d));
            chk($sformatf("d%0d_error", d),  ger, err[d]);
            chk($sformatf("d%0d_cfg_out", d), gco, sh[d][0]);
        end
    endtask

    task automatic rnd_data();
        din = $urandom;
        les = 4'($urandom);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin rnd_data(); cyc(); end
    endtask

    // Shift n bits into instance d (cfg[0] first), optional commit on the last bit.
    task automatic load(input int d, input bit [143:0] cfg, input int n, input bit cmt_last);
        for (int b = 0; b < n; b++) begin
            ce[d] = 1'b1;
            ci[d] = (b < cw(d)) ? cfg[b] : 1'($urandom);
            cc[d] = cmt_last && (b == n - 1);
            rnd_data();
            cyc();
        end
        ce[d] = 1'b0;
        cc[d] = 1'b0;
    endtask

    task automatic commit(input int d);
        cc[d] = 1'b1;
        rnd_data();
        cyc();
        cc[d] = 1'b0;
    endtask

    function automatic bit [143:0] rnd_cfg();
        bit [143:0] c;
        for (int b = 0; b < 144; b++) c[b] = 1'($urandom);
        return c;
    endfunction

    function automatic bit [143:0] set_fld(bit [143:0] c, int base, int w, int v);
        for (int b = 0; b < w; b++) c[base + b] = 1'((v >> b) & 1);
        return c;
    endfunction

    initial begin
        bit [143:0]    cfg;
        bit [3:0][7:0] saved;

        rst = 2'b11; ce = '0; ci = '0; cc = '0;
        din = $urandom; les = 4'b0001;
        cyc(); cyc();
        chk("rst_north_all1", no0, 6'h3f);
        chk("rst_les_all1", lo0, 8'hff);
        chk("rst_loaded", ld0, 1'b0);
        chk("rst_error", er0, 1'b0);
        chk("rst_cfg_out", cout0, 1'b0);
        rst = 2'b00;
        run(3);

        // north mux0 -> south_in[0]
        cfg = set_fld(rnd_cfg(), 0, 3, 3);
        load(0, cfg, 112, 1'b0);
        chk("loaded_after_112", ld0, 1'b1);
        commit(0);
        chk("loaded_fall", ld0, 1'b0);
        chk("err_good_commit", er0, 1'b0);
        din = $urandom; din[2][0] = 1'b1; #1;
        chk("n0_from_s0_hi", no0[0], 1'b1);
        din[2][0] = 1'b0; #1;
        chk("n0_from_s0_lo", no0[0], 1'b0);
        run(10);

        // east mux2 -> north_in[4], LE mux7 -> north_in[5]
        cfg = set_fld(rnd_cfg(), (1*6 + 2)*3, 3, 4);
        cfg = set_fld(cfg, 72 + 7*5, 5, 25);
        load(0, cfg, 112, 1'b0);
        commit(0);
        for (int k = 0; k < 4; k++) begin
            din = $urandom; #1;
            chk("e2_from_n4", eo0[2], din[0][4]);
            chk("le7_from_n5", lo0[7], din[0][5]);
        end
        run(5);

        // partial load, then full load
        load(0, rnd_cfg(), 50, 1'b0);
        commit(0);
        chk("err_partial", er0, 1'b1);
        run(5);
        load(0, rnd_cfg(), 112, 1'b0);
        commit(0);
        chk("err_cleared", er0, 1'b0);
        run(5);

        // over-shift, and commit coincident with the last enable
        load(0, rnd_cfg(), 113, 1'b0);
        commit(0);
        chk("err_over", er0, 1'b1);
        run(3);
        load(0, rnd_cfg(), 112, 1'b1);
        chk("err_commit_with_en", er0, 1'b1);
        run(5);

        // reset mid-load on the registered instance: nothing reaches active
        load(1, rnd_cfg(), 60, 1'b0);
        rst[1] = 1'b1; rnd_data(); cyc(); rst[1] = 1'b0;
        commit(1);
        chk("err_after_abort", er1, 1'b1);
        run(5);

        // W=8 wrap: south mux6 -> west_in[0], south mux7 -> west_in[7], west mux7 -> south_in[7]
        cfg = set_fld(rnd_cfg(), (2*8 + 6)*3, 3, 4);
        cfg = set_fld(cfg, (2*8 + 7)*3, 3, 4);
        cfg = set_fld(cfg, (3*8 + 7)*3, 3, 6);
        load(1, cfg, 144, 1'b0);
        commit(1);
        for (int k = 0; k < 4; k++) begin
            rnd_data(); saved = din;
            cyc();
            chk("s6_from_w0_lag", so1[6], saved[3][0]);
            chk("s7_from_w7_lag", so1[7], saved[3][7]);
            chk("w7_from_s7_lag", wo1[7], saved[2][7]);
        end

        // random configurations on both instances
        for (int r = 0; r < 3; r++)
            for (int d = 0; d < 2; d++) begin
                load(d, rnd_cfg(), cw(d), 1'b0);
                commit(d);
                run(15);
            end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
